hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Pipeline sequencer for the 4-stage SCPU (IF/ID -> ID/EXE -> EXE/DM -> DM/WB).
- Keeps a shadow pipeline of the control metadata of in-flight instructions.
- Drives PC and IF/ID write enables, stage flush/bubble, ALU operand forwarding selects and register-file writeback enable.
- Sits beside the branch control unit; consumes its taken indication and the instruction word held in IF/ID.

Parameters:
LU_STALL, 1, load-use stall length in cycles (legal 1..3)
CNT_W, 8, width of saturating stall/flush performance counters

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
id_ins  in  16  instruction in IF/ID; [15:8] imm, [7:4] op, [3:2] ra, [1:0] rb
br_taken  in  1  branch control requests PC redirect this cycle
pc_we  out  1  program counter load enable
ifid_we  out  1  IF/ID register write enable
ifid_flush  out  1  IF/ID loads NOP at next edge
idex_bubble  out  1  ID/EXE loads NOP at next edge
fwd_a_sel  out  2  EX operand A: 00 regfile, 01 EXE/DM ALU result, 10 DM/WB writeback value
fwd_b_sel  out  2  EX operand B, same encoding
wb_we  out  1  register-file write enable
wb_dst  out  2  register-file write address
stall_cnt  out  CNT_W  saturating count of stall cycles
flush_cnt  out  CNT_W  saturating count of branch flushes

Behaviour:
- Clock and reset: one clock clk; reset rst is synchronous, active-high.
- Opcode classes (package constants):
  - 1..5 ALU (ADD, SUB, NAND, SHL, SHR): read ra and rb, write ra.
  - 7 IN: writes ra.
  - 8 MOV: reads rb, writes ra.
  - 6 OUT: reads ra.
  - C LOAD: writes ra, load.
  - D STORE: reads ra.
  - 9, A, B branches, E RET, 0 NOP: no register read or write.
- Shadow stages ex_q, dm_q, wb_q each hold {valid, wr, ld, dst, src_a, src_b, rd_a, rd_b}.
- Each edge: wb_q<=dm_q, dm_q<=ex_q.
  - ex_q<=decode(id_ins), or all-zero bubble when idex_bubble=1.
- Load-use stall:
  - Trigger: ex_q.valid & ex_q.ld & ex_q.wr, and the ID instruction reads ex_q.dst.
  - Loads the stall counter with LU_STALL-1 and asserts stall.
  - Stall holds while counter is nonzero or the trigger persists.
  - Stall outputs: pc_we=0, ifid_we=0, idex_bubble=1.
  - With LU_STALL=1, the consumer enters EX when the load is in WB and takes fwd=10.
- Branch:
  - If br_taken=1 and no stall: pc_we=1, ifid_flush=1, idex_bubble=0; flush_cnt+1.
  - Exactly one fetched instruction is killed per taken branch.
- Stall and branch in the same cycle: stall wins.
  - br_taken is ignored, with no flush and no count.
  - Branch control re-asserts br_taken once the stall clears.
- Normal cycle: pc_we=1, ifid_we=1, ifid_flush=0, idex_bubble=0.
- Forwarding is combinational from ex_q vs dm_q/wb_q; each operand is resolved independently.
  - EXE/DM match (valid & wr & !ld & dst==src, rd asserted) -> 01.
  - Else DM/WB match (valid & wr) -> 10.
  - Else 00.
  - EXE/DM has priority over DM/WB.
  - A load in EXE/DM never forwards.
- Writeback: wb_we=wb_q.valid & wb_q.wr; wb_dst=wb_q.dst. Writes to any of r0..r3 are allowed.
- Counters: stall_cnt increments on each stall cycle; both counters saturate at all-ones and never wrap.
- During rst=1 (outputs defined combinationally while rst is high):
  - shadow stages invalid, stall counter 0, stall_cnt=0, flush_cnt=0.
  - pc_we=0, ifid_we=0, ifid_flush=1, idex_bubble=1, fwd_a_sel=fwd_b_sel=00, wb_we=0, wb_dst=0.
- Reset mid-stall aborts the stall. The first cycle after reset is a normal cycle.
- Latency: forwarding selects and stall decisions are zero-cycle. Shadow state advances one stage per edge.

Decomposition:
- Package scpu_pkg:
  - opcode constants (OP_NOP..OP_RET).
  - FWD_RF/FWD_EXDM/FWD_DMWB select encodings.
  - stage-metadata struct type.
  - decode function returning {wr, ld, rd_a, rd_b}.
- One sub-module, sat_counter (CNT_W, inc, clear), instantiated twice for stall_cnt and flush_cnt.

Test Plan:
- Reset: hold rst 2 cycles.
  - During reset: pc_we=0, ifid_flush=1, wb_we=0, counters 0.
  - Next cycle: pc_we=1, ifid_we=1.
- ADD r1,r2 then SUB r3,r1 back-to-back -> SUB in EX sees fwd_b_sel=01.
- ADD r1,r2; NOP; SUB r0,r1 -> SUB sees fwd_b_sel=10.
  - When ADD retires: wb_we=1, wb_dst=1.
- LOAD r2 then ADD r2,r0, LU_STALL=1 -> exactly 1 cycle of pc_we=0, ifid_we=0, idex_bubble=1.
  - ADD then gets fwd_a_sel=10; stall_cnt=1.
- Taken branch (br_taken=1 for 1 cycle) -> ifid_flush=1 for one cycle; flush_cnt=1; killed slot never produces wb_we.
- br_taken=1 coincident with load-use stall -> no flush that cycle.
  - Re-asserted br_taken next cycle flushes once; flush_cnt=1.
- 300 stall cycles with CNT_W=8 -> stall_cnt saturates at 255.

Source files
------------

// File: rtl/scpu_pkg.sv
// Shared definitions for the SCPU pipeline sequencer: opcodes, forwarding selects,
// shadow-stage metadata and the register-usage decoder.
package scpu_pkg;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_NAND  = 4'h3;
  localparam logic [3:0] OP_SHL   = 4'h4;
  localparam logic [3:0] OP_SHR   = 4'h5;
  localparam logic [3:0] OP_OUT   = 4'h6;
  localparam logic [3:0] OP_IN    = 4'h7;
  localparam logic [3:0] OP_MOV   = 4'h8;
  localparam logic [3:0] OP_JMP   = 4'h9;
  localparam logic [3:0] OP_JZ    = 4'hA;
  localparam logic [3:0] OP_JC    = 4'hB;
  localparam logic [3:0] OP_LOAD  = 4'hC;
  localparam logic [3:0] OP_STORE = 4'hD;
  localparam logic [3:0] OP_RET   = 4'hE;

  localparam logic [1:0] FWD_RF   = 2'b00;
  localparam logic [1:0] FWD_EXDM = 2'b01;
  localparam logic [1:0] FWD_DMWB = 2'b10;

  typedef struct packed {
    logic       valid;
    logic       wr;
    logic       ld;
    logic [1:0] dst;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic       rd_a;
    logic       rd_b;
  } stage_t;

  typedef struct packed {
    logic wr;
    logic ld;
    logic rd_a;
    logic rd_b;
  } dec_t;

  function automatic dec_t decode(logic [3:0] op);
    dec_t d;
    d = '0;
    case (op)
      OP_ADD, OP_SUB, OP_NAND, OP_SHL, OP_SHR: begin
        d.wr   = 1'b1;
        d.rd_a = 1'b1;
        d.rd_b = 1'b1;
      end
      OP_IN:    d.wr = 1'b1;
      OP_MOV: begin
        d.wr   = 1'b1;
        d.rd_b = 1'b1;
      end
      OP_OUT:   d.rd_a = 1'b1;
      OP_LOAD: begin
        d.wr = 1'b1;
        d.ld = 1'b1;
      end
      OP_STORE: d.rd_a = 1'b1;
      default:  d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; output reads zero while clear is held.
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (clear) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign count = clear ? '0 : cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// SCPU 4-stage pipeline sequencer: load-use stall, branch flush, operand forwarding
// and writeback enable driven from a shadow pipeline of instruction metadata.
import scpu_pkg::*;

module hazard_ctrl #(
  parameter int unsigned LU_STALL = 1,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      id_ins,
  input  logic             br_taken,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             wb_we,
  output logic [1:0]       wb_dst,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0] LuReload = 2'(LU_STALL - 1);

  stage_t     ex_q, dm_q, wb_q;
  stage_t     id_stage;
  dec_t       id_dec;
  logic [1:0] lu_cnt_q, lu_cnt_d;
  logic       lu_trig, stall, stall_inc, flush_inc;

  logic unused_bits;
  assign unused_bits = ^{id_ins[15:8], wb_q.ld, wb_q.src_a, wb_q.src_b, wb_q.rd_a, wb_q.rd_b,
                         dm_q.src_a, dm_q.src_b, dm_q.rd_a, dm_q.rd_b};

  // A load in EXE/DM has no data yet, so only non-load results forward from there.
  function automatic logic [1:0] fwd_sel(stage_t dm, stage_t wb, logic rd, logic [1:0] src);
    logic [1:0] sel;
    sel = FWD_RF;
    if (rd) begin
      if (dm.valid && dm.wr && !dm.ld && (dm.dst == src)) begin
        sel = FWD_EXDM;
      end else if (wb.valid && wb.wr && (wb.dst == src)) begin
        sel = FWD_DMWB;
      end
    end
    return sel;
  endfunction

  always_comb begin
    id_dec         = decode(id_ins[7:4]);
    id_stage       = '0;
    id_stage.valid = 1'b1;
    id_stage.wr    = id_dec.wr;
    id_stage.ld    = id_dec.ld;
    id_stage.dst   = id_ins[3:2];
    id_stage.src_a = id_ins[3:2];
    id_stage.src_b = id_ins[1:0];
    id_stage.rd_a  = id_dec.rd_a;
    id_stage.rd_b  = id_dec.rd_b;
  end

  always_comb begin
    lu_trig = ex_q.valid && ex_q.ld && ex_q.wr &&
              ((id_stage.rd_a && (id_stage.src_a == ex_q.dst)) ||
               (id_stage.rd_b && (id_stage.src_b == ex_q.dst)));
    stall   = lu_trig || (lu_cnt_q != 2'd0);

    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    fwd_a_sel   = fwd_sel(dm_q, wb_q, ex_q.rd_a, ex_q.src_a);
    fwd_b_sel   = fwd_sel(dm_q, wb_q, ex_q.rd_b, ex_q.src_b);
    wb_we       = wb_q.valid && wb_q.wr;
    wb_dst      = wb_q.dst;

    lu_cnt_d = lu_cnt_q;
    if (lu_trig) begin
      lu_cnt_d = LuReload;
    end else if (lu_cnt_q != 2'd0) begin
      lu_cnt_d = lu_cnt_q - 2'd1;
    end

    if (rst) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      fwd_a_sel   = FWD_RF;
      fwd_b_sel   = FWD_RF;
      wb_we       = 1'b0;
      wb_dst      = 2'd0;
    end else if (stall) begin
      // Stall outranks a taken branch; branch control re-asserts it afterwards.
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_bubble = 1'b1;
      stall_inc   = 1'b1;
    end else if (br_taken) begin
      ifid_flush = 1'b1;
      flush_inc  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q     <= '0;
      dm_q     <= '0;
      wb_q     <= '0;
      lu_cnt_q <= 2'd0;
    end else begin
      ex_q     <= idex_bubble ? '0 : id_stage;
      dm_q     <= ex_q;
      wb_q     <= dm_q;
      lu_cnt_q <= lu_cnt_d;
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .clear(rst),
    .inc  (stall_inc),
    .count(stall_cnt)
  );

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_flush_cnt (
    .clk  (clk),
    .clear(rst),
    .inc  (flush_inc),
    .count(flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: reset, forwarding, load-use stall, branch flush and
// counter saturation, each checked against hand-derived values.
module tb_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic [15:0] id_ins;
  logic        br_taken;
  logic        pc_we, ifid_we, ifid_flush, idex_bubble, wb_we;
  logic [1:0]  fwd_a_sel, fwd_b_sel, wb_dst;
  logic [7:0]  stall_cnt, flush_cnt;

  int checks;
  int failures;

  hazard_ctrl #(
    .LU_STALL(1),
    .CNT_W   (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .id_ins     (id_ins),
    .br_taken   (br_taken),
    .pc_we      (pc_we),
    .ifid_we    (ifid_we),
    .ifid_flush (ifid_flush),
    .idex_bubble(idex_bubble),
    .fwd_a_sel  (fwd_a_sel),
    .fwd_b_sel  (fwd_b_sel),
    .wb_we      (wb_we),
    .wb_dst     (wb_dst),
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ins(logic [3:0] op, logic [1:0] ra, logic [1:0] rb);
    return {8'h00, op, ra, rb};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic drain();
    id_ins   = ins(4'h0, 2'd0, 2'd0);
    br_taken = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; id_ins = '0; br_taken = 1'b0;
    for (int c = 0; c < 2; c++) begin
      settle();
      checks++; if (pc_we !== 1'b0) begin failures++; $display("FAIL rst_pc_we got=%0b exp=0", pc_we); end
      checks++; if (ifid_flush !== 1'b1) begin failures++; $display("FAIL rst_ifid_flush got=%0b exp=1", ifid_flush); end
      checks++; if (wb_we !== 1'b0) begin failures++; $display("FAIL rst_wb_we got=%0b exp=0", wb_we); end
      checks++; if (idex_bubble !== 1'b1) begin failures++; $display("FAIL rst_bubble got=%0b exp=1", idex_bubble); end
      checks++; if ({stall_cnt, flush_cnt} !== 16'h0) begin failures++; $display("FAIL rst_cnts got=%0h/%0h exp=0/0", stall_cnt, flush_cnt); end
      tick();
    end
    rst = 1'b0;
    settle();
    checks++; if ({pc_we, ifid_we, ifid_flush, idex_bubble} !== 4'b1100) begin failures++; $display("FAIL post_rst_ctl got=%4b exp=1100", {pc_we, ifid_we, ifid_flush, idex_bubble}); end
    tick();
  endtask

  task automatic test_fwd_exdm();
    id_ins = ins(4'h1, 2'd1, 2'd2);  // ADD r1,r2
    tick();
    id_ins = ins(4'h2, 2'd3, 2'd1);  // SUB r3,r1
    tick();
    id_ins = ins(4'h0, 2'd0, 2'd0);
    settle();
    checks++; if (fwd_b_sel !== 2'b01) begin failures++; $display("FAIL exdm_fwd_b got=%2b exp=01", fwd_b_sel); end
    checks++; if (fwd_a_sel !== 2'b00) begin failures++; $display("FAIL exdm_fwd_a got=%2b exp=00", fwd_a_sel); end
    drain();
  endtask

  task automatic test_fwd_dmwb();
    id_ins = ins(4'h1, 2'd1, 2'd2);  // ADD r1,r2
    tick();
    id_ins = ins(4'h0, 2'd0, 2'd0);
    tick();
    id_ins = ins(4'h2, 2'd0, 2'd1);  // SUB r0,r1
    settle();
    checks++; if (wb_we !== 1'b0) begin failures++; $display("FAIL dmwb_early_wb got=%0b exp=0", wb_we); end
    tick();
    id_ins = ins(4'h0, 2'd0, 2'd0);
    settle();
    checks++; if (fwd_b_sel !== 2'b10) begin failures++; $display("FAIL dmwb_fwd_b got=%2b exp=10", fwd_b_sel); end
    checks++; if (fwd_a_sel !== 2'b00) begin failures++; $display("FAIL dmwb_fwd_a got=%2b exp=00", fwd_a_sel); end
    checks++; if ({wb_we, wb_dst} !== 3'b101) begin failures++; $display("FAIL dmwb_wb got=%0b/%0d exp=1/1", wb_we, wb_dst); end
    drain();
  endtask

  task automatic test_load_use();
    id_ins = ins(4'hC, 2'd2, 2'd0);  // LOAD r2
    tick();
    id_ins = ins(4'h1, 2'd2, 2'd0);  // ADD r2,r0
    settle();
    checks++; if ({pc_we, ifid_we, idex_bubble} !== 3'b001) begin failures++; $display("FAIL lu_stall got=%3b exp=001", {pc_we, ifid_we, idex_bubble}); end
    tick();
    settle();
    checks++; if ({pc_we, ifid_we, idex_bubble} !== 3'b110) begin failures++; $display("FAIL lu_release got=%3b exp=110", {pc_we, ifid_we, idex_bubble}); end
    checks++; if (stall_cnt !== 8'd1) begin failures++; $display("FAIL lu_stall_cnt got=%0d exp=1", stall_cnt); end
    tick();
    id_ins = ins(4'h0, 2'd0, 2'd0);
    settle();
    checks++; if (fwd_a_sel !== 2'b10) begin failures++; $display("FAIL lu_fwd_a got=%2b exp=10", fwd_a_sel); end
    checks++; if (fwd_b_sel !== 2'b00) begin failures++; $display("FAIL lu_fwd_b got=%2b exp=00", fwd_b_sel); end
    checks++; if ({wb_we, wb_dst} !== 3'b110) begin failures++; $display("FAIL lu_wb got=%0b/%0d exp=1/2", wb_we, wb_dst); end
    drain();
  endtask

  task automatic test_branch();
    id_ins = ins(4'h9, 2'd0, 2'd0);  // JMP
    br_taken = 1'b1;
    settle();
    checks++; if ({pc_we, ifid_flush, idex_bubble} !== 3'b110) begin failures++; $display("FAIL br_ctl got=%3b exp=110", {pc_we, ifid_flush, idex_bubble}); end
    tick();
    br_taken = 1'b0;
    id_ins = ins(4'h0, 2'd0, 2'd0);  // killed slot reaches ID as a NOP
    settle();
    checks++; if (ifid_flush !== 1'b0) begin failures++; $display("FAIL br_one_flush got=%0b exp=0", ifid_flush); end
    checks++; if (flush_cnt !== 8'd1) begin failures++; $display("FAIL br_flush_cnt got=%0d exp=1", flush_cnt); end
    for (int c = 0; c < 4; c++) begin
      tick();
      settle();
      checks++; if (wb_we !== 1'b0) begin failures++; $display("FAIL br_killed_wb cyc=%0d got=%0b exp=0", c, wb_we); end
    end
    drain();
  endtask

  task automatic test_stall_branch();
    id_ins = ins(4'hC, 2'd1, 2'd0);  // LOAD r1
    tick();
    id_ins = ins(4'h1, 2'd1, 2'd3);  // ADD r1,r3
    br_taken = 1'b1;
    settle();
    checks++; if ({pc_we, ifid_flush} !== 2'b00) begin failures++; $display("FAIL sb_no_flush got=%2b exp=00", {pc_we, ifid_flush}); end
    tick();
    settle();
    checks++; if (flush_cnt !== 8'd1) begin failures++; $display("FAIL sb_cnt_hold got=%0d exp=1", flush_cnt); end
    checks++; if ({pc_we, ifid_flush} !== 2'b11) begin failures++; $display("FAIL sb_reflush got=%2b exp=11", {pc_we, ifid_flush}); end
    tick();
    br_taken = 1'b0;
    settle();
    checks++; if (flush_cnt !== 8'd2) begin failures++; $display("FAIL sb_flush_cnt got=%0d exp=2", flush_cnt); end
    checks++; if (stall_cnt !== 8'd2) begin failures++; $display("FAIL sb_stall_cnt got=%0d exp=2", stall_cnt); end
    drain();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 300; i++) begin
      id_ins = ins(4'hC, 2'd2, 2'd0);
      tick();
      id_ins = ins(4'h1, 2'd2, 2'd0);
      tick();
      tick();
      if (i == 99) begin
        checks++; if (stall_cnt !== 8'd102) begin failures++; $display("FAIL sat_mid got=%0d exp=102", stall_cnt); end
      end
    end
    settle();
    checks++; if (stall_cnt !== 8'd255) begin failures++; $display("FAIL sat_stall_cnt got=%0d exp=255", stall_cnt); end
    checks++; if (flush_cnt !== 8'd2) begin failures++; $display("FAIL sat_flush_cnt got=%0d exp=2", flush_cnt); end
    drain();
  endtask

  task automatic test_reset_mid_stall();
    id_ins = ins(4'hC, 2'd2, 2'd0);
    tick();
    id_ins = ins(4'h1, 2'd2, 2'd0);
    rst = 1'b1;
    settle();
    checks++; if ({pc_we, ifid_we, ifid_flush, idex_bubble} !== 4'b0011) begin failures++; $display("FAIL mrst_ctl got=%4b exp=0011", {pc_we, ifid_we, ifid_flush, idex_bubble}); end
    checks++; if (stall_cnt !== 8'd0) begin failures++; $display("FAIL mrst_stall_cnt got=%0d exp=0", stall_cnt); end
    tick();
    rst = 1'b0;
    settle();
    checks++; if ({pc_we, ifid_we, idex_bubble} !== 3'b110) begin failures++; $display("FAIL mrst_abort got=%3b exp=110", {pc_we, ifid_we, idex_bubble}); end
    tick();
    settle();
    checks++; if (stall_cnt !== 8'd0) begin failures++; $display("FAIL mrst_no_count got=%0d exp=0", stall_cnt); end
    drain();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    id_ins = '0;
    br_taken = 1'b0;
    test_reset();
    test_fwd_exdm();
    test_fwd_dmwb();
    test_load_use();
    test_branch();
    test_stall_branch();
    test_saturation();
    test_reset_mid_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule
